// File: rtl/fc_soc_event_queue_pkg.sv
// fc_evt_pkg: shared constants and helpers for the SoC event queue.
//   OVF_CNT_W     : width of the dropped-event counter exposed on ovf_cnt_o.
//   min_id_width(): smallest event ID width able to hold base+nb-1, used to
//                   check the EVENT_ID_WIDTH parameter at elaboration.
package fc_evt_pkg;

    localparam int unsigned OVF_CNT_W = 16;

    function automatic int unsigned min_id_width(input int unsigned base,
                                                 input int unsigned nb);
        int unsigned max_id;
        int unsigned w;
        max_id = base + nb - 1;
        w      = 1;
        for (int i = 1; i < 32; i++) begin
            if ((max_id >> i) != 0) w = i + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/fc_soc_event_queue_rr_arb.sv
// fc_evt_rr_arb: purely combinational round-robin arbiter.
//   req       in  NB_REQ  requesting sources
//   en        in  1       grant allowed this cycle
//   rr_ptr    in  IDX_W   highest-priority index (register lives in parent)
//   gnt       out NB_REQ  one-hot grant
//   gnt_idx   out IDX_W   index of granted source
//   gnt_valid out 1       a grant was issued
module fc_evt_rr_arb #(
    parameter int unsigned NB_REQ = 8,
    localparam int unsigned IDX_W = (NB_REQ > 1) ? $clog2(NB_REQ) : 1
) (
    input  logic [NB_REQ-1:0] req,
    input  logic              en,
    input  logic [IDX_W-1:0]  rr_ptr,
    output logic [NB_REQ-1:0] gnt,
    output logic [IDX_W-1:0]  gnt_idx,
    output logic              gnt_valid
);

    int k;

    // Walk the sources starting at rr_ptr; the first requester wins.
    always_comb begin
        gnt       = '0;
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        k         = 0;
        for (int off = 0; off < int'(NB_REQ); off++) begin
            k = (int'(rr_ptr) + off) % int'(NB_REQ);
            if (en && !gnt_valid && req[k]) begin
                gnt_valid = 1'b1;
                gnt_idx   = IDX_W'(k);
                gnt[k]    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fc_soc_event_queue.sv
// fc_soc_event_queue: collects single-cycle event pulses from NB_EVT sources,
// keeps a saturating pending count per source, and serialises them as event
// IDs (EVT_ID_BASE + source index) into a small output FIFO feeding the FC
// event FIFO port.
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   evt_i                event pulses, one bit per source
//   event_fifo_valid_o   head entry valid
//   event_fifo_data_o    head event ID (0 when empty)
//   event_fifo_fulln_i   consumer not full
//   pending_o            per-source counter nonzero (debug)
//   overflow_o           one-cycle pulse after any event is dropped
//   ovf_cnt_o            saturating dropped-event count
// Handshake: a transfer happens in a cycle where event_fifo_valid_o and
// event_fifo_fulln_i are both high; data stays stable while valid is held.
// Macro FC_EVT_OVF_CNT_EN: when defined, ovf_cnt_o is a live 16-bit counter
// (adds the number of sources dropping each cycle, saturating at 0xFFFF);
// when undefined, ovf_cnt_o is tied to 0.
module fc_soc_event_queue
    import fc_evt_pkg::*;
#(
    parameter int unsigned NB_EVT         = 8,
    parameter int unsigned EVENT_ID_WIDTH = 8,
    parameter int unsigned EVT_ID_BASE    = 0,
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned PEND_W         = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [NB_EVT-1:0]         evt_i,
    output logic                      event_fifo_valid_o,
    output logic [EVENT_ID_WIDTH-1:0] event_fifo_data_o,
    input  logic                      event_fifo_fulln_i,
    output logic [NB_EVT-1:0]         pending_o,
    output logic                      overflow_o,
    output logic [OVF_CNT_W-1:0]      ovf_cnt_o
);

    localparam int unsigned IDX_W = (NB_EVT > 1) ? $clog2(NB_EVT) : 1;
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    if (EVENT_ID_WIDTH < min_id_width(EVT_ID_BASE, NB_EVT)) begin : g_id_width_check
        $error("EVENT_ID_WIDTH too small for EVT_ID_BASE+NB_EVT-1");
    end

    logic [PEND_W-1:0]         cnt_q [NB_EVT];
    logic [PEND_W-1:0]         cnt_d [NB_EVT];
    logic [EVENT_ID_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [EVENT_ID_WIDTH-1:0] mem_d [FIFO_DEPTH];
    logic [NB_EVT-1:0]         req, gnt, drop;
    logic [IDX_W-1:0]          gnt_idx, rr_ptr_q, rr_ptr_d;
    logic                      gnt_valid, pop, fifo_free;
    logic [EVENT_ID_WIDTH-1:0] push_id;
    logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]          count_q, count_d;
    logic                      overflow_q, overflow_d;

    always_comb begin
        for (int i = 0; i < int'(NB_EVT); i++) req[i] = (cnt_q[i] != '0);
    end

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    always_comb begin
        pop       = (count_q != '0) && event_fifo_fulln_i;
        fifo_free = (count_q < CNT_W'(FIFO_DEPTH)) || pop;
    end

    fc_evt_rr_arb #(.NB_REQ(NB_EVT)) u_arb (
        .req       (req),
        .en        (fifo_free),
        .rr_ptr    (rr_ptr_q),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    // Pending counters: +event -grant; a saturated counter drops the event.
    always_comb begin
        for (int i = 0; i < int'(NB_EVT); i++) begin
            drop[i]  = evt_i[i] && !gnt[i] && (cnt_q[i] == PEND_MAX);
            cnt_d[i] = cnt_q[i];
            if (evt_i[i] && !gnt[i] && !drop[i]) begin
                cnt_d[i] = cnt_q[i] + PEND_W'(1);
            end else if (!evt_i[i] && gnt[i]) begin
                cnt_d[i] = cnt_q[i] - PEND_W'(1);
            end
        end
        overflow_d = |drop;
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (gnt_valid) begin
            rr_ptr_d = (gnt_idx == IDX_W'(NB_EVT - 1)) ? '0 : gnt_idx + IDX_W'(1);
        end
    end

    always_comb begin
        push_id  = EVENT_ID_WIDTH'(EVT_ID_BASE + 32'(gnt_idx));
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (gnt_valid) begin
            mem_d[wr_ptr_q] = push_id;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({gnt_valid, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(NB_EVT); i++) cnt_q[i] <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
            rr_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            mem_q      <= mem_d;
            rr_ptr_q   <= rr_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

`ifdef FC_EVT_OVF_CNT_EN
    logic [OVF_CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;
    logic [OVF_CNT_W:0]   ovf_sum;
    logic [6:0]           drop_num;

    // Several sources can drop in one cycle; add them all, saturating.
    always_comb begin
        drop_num = '0;
        for (int i = 0; i < int'(NB_EVT); i++) drop_num = drop_num + 7'(drop[i]);
        ovf_sum   = {1'b0, ovf_cnt_q} + (OVF_CNT_W + 1)'(drop_num);
        ovf_cnt_d = ovf_sum[OVF_CNT_W] ? '1 : ovf_sum[OVF_CNT_W-1:0];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) ovf_cnt_q <= '0;
        else         ovf_cnt_q <= ovf_cnt_d;
    end

    assign ovf_cnt_o = ovf_cnt_q;
`else
    assign ovf_cnt_o = '0;
`endif

    assign event_fifo_valid_o = (count_q != '0);
    assign event_fifo_data_o  = event_fifo_valid_o ? mem_q[rd_ptr_q] : '0;
    assign pending_o          = req;
    assign overflow_o         = overflow_q;

endmodule
